div_unit_iter: RTL and testbench

//  Iterative radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per clock.

---
 rtl/div_unit_iter.sv | 127 ++++++++++++
 tb/tb_div_unit_iter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// start/busy/done handshake, sign fix-up and divide-by-zero handling in a final cycle.
module div_unit_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic                  iSigned,
  input  logic [DATA_WIDTH-1:0] iDividend,
  input  logic [DATA_WIDTH-1:0] iDivisor,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [DATA_WIDTH-1:0] oQuotient,
  output logic [DATA_WIDTH-1:0] oRemainder,
  output logic                  oDivZero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   dvd_raw;
  logic [W-1:0]   dvs_mag;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [CW-1:0]  cnt;
  logic           q_neg;
  logic           r_neg;
  logic           dz;

  logic [W:0]     sh;
  logic [W+1:0]   diff;
  logic           borrow;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   dvd_mag;
  logic [W-1:0]   dvs_mag_in;

  assign dvd_mag    = (iSigned && iDividend[W-1]) ? (~iDividend + W'(1)) : iDividend;
  assign dvs_mag_in = (iSigned && iDivisor[W-1])  ? (~iDivisor  + W'(1)) : iDivisor;

  // Shifted partial remainder needs W+1 bits; the extra borrow bit decides restore.
  always_comb begin
    sh      = {rem, quo[W-1]};
    diff    = {1'b0, sh} - {2'b00, dvs_mag};
    borrow  = diff[W+1];
    rem_nxt = borrow ? sh[W-1:0] : diff[W-1:0];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (iStart) state_nxt = RUN;
      RUN:  if (cnt == CW'(W - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign oBusy = (state != IDLE);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dvd_raw    <= '0;
      dvs_mag    <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz         <= 1'b0;
      oDone      <= 1'b0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivZero   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            dvd_raw <= iDividend;
            dvs_mag <= dvs_mag_in;
            quo     <= dvd_mag;
            rem     <= '0;
            cnt     <= '0;
            q_neg   <= iSigned & (iDividend[W-1] ^ iDivisor[W-1]);
            r_neg   <= iSigned & iDividend[W-1];
            dz      <= (iDivisor == '0);
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= {quo[W-2:0], ~borrow};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          // Divide-by-zero reports the raw dividend, bypassing sign correction.
          if (dz) begin
            oQuotient  <= '1;
            oRemainder <= dvd_raw;
          end else begin
            oQuotient  <= q_neg ? (~quo + W'(1)) : quo;
            oRemainder <= r_neg ? (~rem + W'(1)) : rem;
          end
          oDivZero <= dz;
          oDone    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_iter.sv
// Directed bench for div_unit_iter: scoreboard of expected results popped on oDone,
// plus latency, busy, start-while-busy, restart and mid-operation reset checks.
module tb_div_unit_iter;

  logic        iClk;
  logic        iRst_n;
  logic        iStart;
  logic        iSigned;
  logic [31:0] iDividend;
  logic [31:0] iDivisor;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oQuotient;
  logic [31:0] oRemainder;
  logic        oDivZero;

  div_unit_iter #(.DATA_WIDTH(32)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iStart     (iStart),
    .iSigned    (iSigned),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivZero   (oDivZero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } res_t;

  res_t sb[$];
  res_t last_exp;
  int   n_assert = 0;
  int   n_fail   = 0;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    res_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.dz = 1'b0;
    end else if (sg) begin
      e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every oDone pops one expected result
  always @(negedge iClk) begin
    if (oDone) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_done: observed done with %0d pending expected 1+", sb.size());
      end
      if (sb.size() > 0) begin
        res_t e;
        e = sb.pop_front();
        chk("quotient", oQuotient, e.q);
        chk("remainder", oRemainder, e.r);
        chk("divzero", {31'd0, oDivZero}, {31'd0, e.dz});
      end
    end
  end

  // Drives a start now; returns #1 after the start edge with operands scrambled.
  task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b);
    iSigned   = sg;
    iDividend = a;
    iDivisor  = b;
    iStart    = 1'b1;
    last_exp  = model(sg, a, b);
    sb.push_back(last_exp);
    @(posedge iClk);
    #1;
    iStart    = 1'b0;
    iDividend = $urandom;
    iDivisor  = $urandom;
    iSigned   = ~sg;
    chk("busy_after_start", {31'd0, oBusy}, 32'd1);
  endtask

  // Counts edges after the start edge until oDone; pulses iStart on edges poke_a/poke_b.
  task automatic wait_done(input int poke_a, input int poke_b, output int edges);
    edges = 0;
    while (edges < 40) begin
      iStart = (edges == poke_a - 1 || edges == poke_b - 1);
      if (iStart) begin
        iDividend = $urandom;
        iDivisor  = $urandom_range(1, 9);
      end
      @(posedge iClk);
      #1;
      edges++;
      if (oDone) break;
      if (edges <= 32) chk("busy_running", {31'd0, oBusy}, 32'd1);
    end
    iStart = 1'b0;
    chk("done_latency", edges, 33);
    chk("busy_in_done", {31'd0, oBusy}, 32'd0);
  endtask

  task automatic op(input bit sg, input logic [31:0] a, input logic [31:0] b);
    int e;
    @(negedge iClk);
    issue(sg, a, b);
    wait_done(-10, -10, e);
  endtask

  initial begin
    int e;
    iRst_n = 1'b0; iStart = 1'b0; iSigned = 1'b0; iDividend = '0; iDivisor = '0;
    #12;
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_done", {31'd0, oDone}, 32'd0);
    chk("rst_q", oQuotient, 32'd0);
    chk("rst_r", oRemainder, 32'd0);
    chk("rst_dz", {31'd0, oDivZero}, 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;

    op(1'b0, 32'd7, 32'd2);
    op(1'b1, 32'hFFFF_FFF9, 32'd2);
    op(1'b1, 32'd7, 32'hFFFF_FFFE);
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    op(1'b0, 32'h0000_1234, 32'd0);
    op(1'b1, 32'hFFFF_FF00, 32'd0);
    op(1'b0, 32'd100, 32'd7);
    op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // Start pulses at E5 and E20 must be ignored
    @(negedge iClk);
    issue(1'b0, 32'd1000, 32'd33);
    wait_done(5, 20, e);

    // Restart in the done cycle; old result must be held until the new FIX edge
    issue(1'b1, 32'hFFFF_F000, 32'd3);
    chk("hold_q", oQuotient, 32'd30);
    chk("hold_r", oRemainder, 32'd10);
    wait_done(-10, -10, e);

    // Asynchronous reset at E10 aborts the operation without oDone
    @(negedge iClk);
    issue(1'b0, 32'd999, 32'd10);
    repeat (9) @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, oBusy}, 32'd0);
    chk("abort_done", {31'd0, oDone}, 32'd0);
    chk("abort_q", oQuotient, 32'd0);
    chk("abort_r", oRemainder, 32'd0);
    chk("abort_dz", {31'd0, oDivZero}, 32'd0);
    sb.delete();
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (40) begin
      @(posedge iClk);
      #1;
      chk("no_done_after_abort", {31'd0, oDone}, 32'd0);
    end
    op(1'b0, 32'd999, 32'd10);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i == 3) ? 32'd1 : ($urandom >> (i * 4));
      op(i[0], a, b);
    end

    repeat (3) @(negedge iClk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
